fcmp_share_ctrl: RTL

Arbitrates one registered floating-point compare unit (FEQ/FLT/FLE on IEEE single) among NREQ requesters using round-robin. Each requester uses a valid/ready request channel. The single shared result slot returns a 32-bit 0/1 result tagged with the requester index, under resp_ready backpressure. It sits between the integer-pipeline issue ports and the FPU comparison path, so several issue sources can share one comparator.

---
 rtl/fcmp_share_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fcmp_share_ctrl.sv
// fcmp_share_ctrl
//   Shares one registered IEEE-single compare unit (FEQ/FLT/FLE) among NREQ
//   requesters with round-robin arbitration.
//   The result comes back through a single output slot. That slot is tagged
//   with the index of the requester that owns the result, and it obeys
//   resp_ready backpressure.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rstn       : asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept, one-hot or zero (combinational)
//   req_op     : op of requester i at [2i+1:2i]
//                00 FEQ, 01 FLT, 10 FLE, 11 reserved (result 0)
//   req_x1     : operand 1 of requester i at [32i+31:32i]
//   req_x2     : operand 2 of requester i, same packing
//   resp_valid : result slot is occupied
//   resp_ready : consumer takes the result this cycle
//   resp_id    : index of the requester owning the result
//   resp_y     : 32'h1 for true, 32'h0 for false
module fcmp_share_ctrl #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_x1,
   input  logic [32*NREQ-1:0]   req_x2,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [31:0]          resp_y
);

   localparam int PW = IDW + 1;

   logic              resp_valid_q, resp_valid_d;
   logic [IDW-1:0]    resp_id_q, resp_id_d;
   logic [31:0]       resp_y_q, resp_y_d;
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;

   logic              slot_free;
   logic              gnt_vld;
   logic [IDW-1:0]    gnt_idx;
   logic [PW-1:0]     sum;
   logic [IDW-1:0]    cand;

   logic [1:0]        op_a [NREQ];
   logic [31:0]       x1_a [NREQ];
   logic [31:0]       x2_a [NREQ];

   // This function maps an IEEE single to a key whose unsigned order follows
   // numeric order.
   // Both zeros share one key. Negative values are bit-inverted, so a larger
   // magnitude gives a smaller key.
   function automatic logic [31:0] fkey(input logic [31:0] x);
      logic [30:0] em;
      em = x[30:0];
      if (em == 31'd0)
         fkey = {1'b1, 31'd0};
      else if (!x[31])
         fkey = {1'b1, em};
      else
         fkey = {1'b0, ~em};
   endfunction

   function automatic logic [31:0] fcmp(input logic [1:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
      logic [31:0] ka;
      logic [31:0] kb;
      logic        r;
      ka = fkey(a);
      kb = fkey(b);
      case (op)
         2'b00:   r = (ka == kb);
         2'b01:   r = (ka <  kb);
         2'b10:   r = (ka <= kb);
         default: r = 1'b0;
      endcase
      fcmp = {31'd0, r};
   endfunction

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = req_op[2*i +: 2];
         x1_a[i] = req_x1[32*i +: 32];
         x2_a[i] = req_x2[32*i +: 32];
      end
   end

   // A new request may enter only when the slot is empty, or when the slot
   // is being drained in this same cycle.
   assign slot_free = ~resp_valid_q | resp_ready;

   // Round-robin search.
   // The search starts one past the last grant and wraps modulo NREQ.
   // rr_ptr+k never exceeds 2*NREQ-1, so one conditional subtract is enough
   // for the modulo.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      cand    = '0;
      if (slot_free) begin
         for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + PW'(k);
            if (sum >= PW'(NREQ))
               sum = sum - PW'(NREQ);
            cand = sum[IDW-1:0];
            if (!gnt_vld && req_valid[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

   always_comb begin
      resp_valid_d = resp_valid_q & ~resp_ready;
      resp_id_d    = resp_id_q;
      resp_y_d     = resp_y_q;
      rr_ptr_d     = rr_ptr_q;
      if (gnt_vld) begin
         resp_valid_d = 1'b1;
         resp_id_d    = gnt_idx;
         resp_y_d     = fcmp(op_a[gnt_idx], x1_a[gnt_idx], x2_a[gnt_idx]);
         rr_ptr_d     = gnt_idx;
      end
   end

   // Result register: a grant loads the slot one edge after acceptance.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_y_q     <= '0;
         rr_ptr_q     <= IDW'(NREQ - 1);
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_y_q     <= resp_y_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_y     = resp_y_q;

endmodule
